// File: rtl/sad_search_ctrl.sv
// Block-match search sequencer: issues candidate indices into the SAD execute
// pipeline and keeps the running minimum of the tagged results it gets back.
//
// state   | meaning
// IDLE    | waiting for Start, issue outputs parked at zero
// ISSUE   | issuing Count=0..NUM_POS-1, one per unstalled cycle
// DRAIN   | all issued, collecting the remaining results
// DONE    | one-cycle completion pulse, best result frozen
module sad_search_ctrl #(
    parameter int NUM_POS = 64,
    parameter int SAD_W   = 12
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Stall,
    output logic [5:0]       Count,
    output logic             C_EN,
    input  logic             SadValid,
    input  logic [SAD_W-1:0] Sad,
    input  logic [5:0]       SadCount,
    output logic             Busy,
    output logic             Done,
    output logic [SAD_W-1:0] BestSad,
    output logic [5:0]       BestCount,
    output logic             Err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [6:0] LAST    = 7'(NUM_POS);

    logic [1:0]       state_q, state_d;
    logic [5:0]       count_q, count_d;
    logic             c_en_q, c_en_d;
    logic [6:0]       nxt_q, nxt_d;
    logic [6:0]       rx_q, rx_d;
    logic [SAD_W-1:0] best_sad_q, best_sad_d;
    logic [5:0]       best_cnt_q, best_cnt_d;
    logic             err_q, err_d;
    logic             busy_q, done_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        c_en_d     = 1'b0;
        nxt_d      = nxt_q;
        rx_d       = rx_q;
        best_sad_d = best_sad_q;
        best_cnt_d = best_cnt_q;
        err_d      = err_q;

        // Results are consumed independently of Stall; surplus results past NUM_POS are dropped.
        if ((state_q == S_ISSUE || state_q == S_DRAIN) && SadValid && rx_q != LAST) begin
            if (SadCount != rx_q[5:0]) begin
                err_d = 1'b1;
            end
            rx_d = rx_q + 7'd1;
            if (Sad < best_sad_q) begin
                best_sad_d = Sad;
                best_cnt_d = SadCount;
            end
        end

        case (state_q)
            S_IDLE: begin
                count_d = 6'd0;
                if (Start) begin
                    state_d    = S_ISSUE;
                    best_sad_d = '1;
                    best_cnt_d = 6'd0;
                    rx_d       = 7'd0;
                    err_d      = 1'b0;
                    c_en_d     = !Stall;
                    nxt_d      = {6'd0, !Stall};
                end
            end
            S_ISSUE: begin
                // Count shows the pending index, so a stall holds it without advancing.
                if (nxt_q == LAST) begin
                    state_d = S_DRAIN;
                    count_d = 6'd0;
                end else begin
                    count_d = nxt_q[5:0];
                    c_en_d  = !Stall;
                    nxt_d   = nxt_q + {6'd0, !Stall};
                end
            end
            S_DRAIN: begin
                if (rx_d == LAST) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            count_q    <= 6'd0;
            c_en_q     <= 1'b0;
            nxt_q      <= 7'd0;
            rx_q       <= 7'd0;
            best_sad_q <= '1;
            best_cnt_q <= 6'd0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            c_en_q     <= c_en_d;
            nxt_q      <= nxt_d;
            rx_q       <= rx_d;
            best_sad_q <= best_sad_d;
            best_cnt_q <= best_cnt_d;
            err_q      <= err_d;
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign Count     = count_q;
    assign C_EN      = c_en_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign BestSad   = best_sad_q;
    assign BestCount = best_cnt_q;
    assign Err       = err_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Bench for sad_search_ctrl: a 64-position instance driven through a tb-side
// loopback pipeline, plus a 1-position instance driven directly.
module tb_sad_search_ctrl;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Rst, Start, Stall, SadValid;
    logic [11:0] Sad;
    logic [5:0]  SadCount;
    logic [5:0]  Count;
    logic        C_EN, Busy, Done, Err;
    logic [11:0] BestSad;
    logic [5:0]  BestCount;

    logic        Start1, Stall1, SadValid1;
    logic [11:0] Sad1;
    logic [5:0]  SadCount1;
    logic [5:0]  Count1;
    logic        C_EN1, Busy1, Done1, Err1;
    logic [11:0] BestSad1;
    logic [5:0]  BestCount1;

    sad_search_ctrl #(.NUM_POS(64), .SAD_W(12)) u_dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Stall(Stall),
        .Count(Count), .C_EN(C_EN), .SadValid(SadValid), .Sad(Sad),
        .SadCount(SadCount), .Busy(Busy), .Done(Done), .BestSad(BestSad),
        .BestCount(BestCount), .Err(Err)
    );

    sad_search_ctrl #(.NUM_POS(1), .SAD_W(12)) u_dut1 (
        .Clk(Clk), .Rst(Rst), .Start(Start1), .Stall(Stall1),
        .Count(Count1), .C_EN(C_EN1), .SadValid(SadValid1), .Sad(Sad1),
        .SadCount(SadCount1), .Busy(Busy1), .Done(Done1), .BestSad(BestSad1),
        .BestCount(BestCount1), .Err(Err1)
    );

    int total = 0;
    int bad   = 0;
    int mode, corrupt, stall_lo, stall_hi, cyc, done_cnt;

    logic [5:0]  exp_q[$];
    logic [5:0]  obs_q[$];
    int          obs_cyc[$];
    logic        pv[3];
    logic [11:0] ps[3];
    logic [5:0]  pt[3];
    logic        cen_log[256];
    logic [5:0]  cnt_log[256];

    function automatic logic [11:0] sad_of(input logic [5:0] idx);
        if (mode == 1) return 12'd50;
        return 12'(100 - int'(idx));
    endfunction

    function automatic void model_best(output logic [11:0] b, output logic [5:0] bc);
        logic [11:0] s;
        b  = '1;
        bc = 6'd0;
        for (int i = 0; i < 64; i++) begin
            s = sad_of(6'(i));
            if (s < b) begin
                b  = s;
                bc = 6'(i);
            end
        end
    endfunction

    // One clock of the 64-position instance: log outputs, advance the loopback pipe, set Stall.
    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
        if (cyc >= 0 && cyc < 256) begin
            cen_log[cyc] = C_EN;
            cnt_log[cyc] = Count;
        end
        if (C_EN) begin
            obs_q.push_back(Count);
            obs_cyc.push_back(cyc);
        end
        if (Done) done_cnt++;
        SadValid = pv[2];
        Sad      = ps[2];
        SadCount = pt[2];
        pv[2] = pv[1]; ps[2] = ps[1]; pt[2] = pt[1];
        pv[1] = pv[0]; ps[1] = ps[0]; pt[1] = pt[0];
        pv[0] = C_EN;
        ps[0] = sad_of(Count);
        pt[0] = (int'(Count) == corrupt) ? Count + 6'd1 : Count;
        Stall = (cyc + 1 >= stall_lo && cyc + 1 <= stall_hi);
    endtask

    task automatic begin_search();
        done_cnt = 0;
        cyc      = -1;
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(6'(i));
        Stall = (stall_lo <= 0 && stall_hi >= 0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic finish_search(output bit got);
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            if (Done) got = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        total++; if (C_EN !== 1'b0) begin bad++; $display("FAIL reset_cen got=%0b want=0", C_EN); end
        total++; if (Count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", Count); end
        total++; if (Busy !== 1'b0 || Done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%0b%0b want=00", Busy, Done); end
        total++; if (BestSad !== 12'hFFF) begin bad++; $display("FAIL reset_bestsad got=%0h want=fff", BestSad); end
        total++; if (BestCount !== 6'd0 || Err !== 1'b0) begin bad++; $display("FAIL reset_bestcnt_err got=%0d/%0b want=0/0", BestCount, Err); end
        @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    task automatic test_basic();
        bit got;
        logic [11:0] eb;
        logic [5:0]  ec, e, o;
        mode = 0;
        model_best(eb, ec);
        begin_search();
        finish_search(got);
        total++; if (!got) begin bad++; $display("FAIL basic_done_timeout got=0 want=1"); end
        total++; if (Busy !== 1'b1) begin bad++; $display("FAIL basic_busy_in_done got=%0b want=1", Busy); end
        total++; if (obs_q.size() != 64) begin bad++; $display("FAIL basic_issue_count got=%0d want=64", obs_q.size()); end
        else begin
            total++;
            if (obs_cyc[0] != 0 || obs_cyc[63] != 63) begin
                bad++; $display("FAIL basic_issue_window got=%0d..%0d want=0..63", obs_cyc[0], obs_cyc[63]);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL basic_issue_idx got=%0d want=%0d", o, e); end
        end
        for (int i = 0; i < 4; i++) tick();
        total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", done_cnt); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL basic_busy_idle got=%0b want=0", Busy); end
        total++; if (BestSad !== eb) begin bad++; $display("FAIL basic_bestsad got=%0d want=%0d", BestSad, eb); end
        total++; if (BestCount !== ec) begin bad++; $display("FAIL basic_bestcount got=%0d want=%0d", BestCount, ec); end
        total++; if (Err !== 1'b0) begin bad++; $display("FAIL basic_err got=%0b want=0", Err); end
    endtask

    task automatic test_stall();
        bit got;
        logic [11:0] eb;
        logic [5:0]  ec, e, o;
        mode = 0;
        model_best(eb, ec);
        stall_lo = 5;
        stall_hi = 7;
        begin_search();
        finish_search(got);
        stall_lo = 1000;
        stall_hi = -1;
        Stall    = 1'b0;
        total++; if (!got) begin bad++; $display("FAIL stall_done_timeout got=0 want=1"); end
        for (int k = 5; k <= 7; k++) begin
            total++;
            if (cen_log[k] !== 1'b0 || cnt_log[k] !== 6'd5) begin
                bad++; $display("FAIL stall_hold cyc=%0d got=%0b/%0d want=0/5", k, cen_log[k], cnt_log[k]);
            end
        end
        total++; if (cen_log[8] !== 1'b1 || cnt_log[8] !== 6'd5) begin bad++; $display("FAIL stall_resume got=%0b/%0d want=1/5", cen_log[8], cnt_log[8]); end
        total++; if (obs_q.size() != 64) begin bad++; $display("FAIL stall_issue_count got=%0d want=64", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL stall_issue_idx got=%0d want=%0d", o, e); end
        end
        total++; if (BestSad !== eb || BestCount !== ec) begin bad++; $display("FAIL stall_best got=%0d@%0d want=%0d@%0d", BestSad, BestCount, eb, ec); end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_tie();
        bit got;
        logic [11:0] eb;
        logic [5:0]  ec;
        mode = 1;
        model_best(eb, ec);
        begin_search();
        finish_search(got);
        total++; if (!got) begin bad++; $display("FAIL tie_done_timeout got=0 want=1"); end
        total++; if (BestSad !== eb || BestCount !== ec) begin bad++; $display("FAIL tie_best got=%0d@%0d want=%0d@%0d", BestSad, BestCount, eb, ec); end
        for (int i = 0; i < 4; i++) tick();
        mode = 0;
    endtask

    task automatic test_tag_err();
        bit got;
        corrupt = 10;
        begin_search();
        finish_search(got);
        corrupt = -1;
        total++; if (!got) begin bad++; $display("FAIL tagerr_done_timeout got=0 want=1"); end
        for (int i = 0; i < 4; i++) tick();
        total++; if (Err !== 1'b1) begin bad++; $display("FAIL tagerr_sticky got=%0b want=1", Err); end
        begin_search();
        total++; if (Err !== 1'b0) begin bad++; $display("FAIL tagerr_clear_on_start got=%0b want=0", Err); end
        finish_search(got);
        total++; if (!got || Err !== 1'b0) begin bad++; $display("FAIL tagerr_clean_run got=%0b/%0b want=1/0", got, Err); end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_mid_reset();
        bit got, hit;
        logic [5:0] e, o;
        hit = 1'b0;
        begin_search();
        for (int i = 0; i < 100 && !hit; i++) begin
            if (C_EN && Count == 6'd20) hit = 1'b1;
            else tick();
        end
        total++; if (!hit) begin bad++; $display("FAIL midrst_reach20 got=0 want=1"); end
        #2;
        Rst = 1'b1;
        #1;
        total++; if (C_EN !== 1'b0 || Count !== 6'd0 || Busy !== 1'b0) begin bad++; $display("FAIL midrst_outputs got=%0b/%0d/%0b want=0/0/0", C_EN, Count, Busy); end
        total++; if (BestSad !== 12'hFFF) begin bad++; $display("FAIL midrst_bestsad got=%0h want=fff", BestSad); end
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        total++; if (BestSad !== 12'hFFF || Err !== 1'b0 || Busy !== 1'b0) begin bad++; $display("FAIL midrst_late_results got=%0h/%0b/%0b want=fff/0/0", BestSad, Err, Busy); end
        begin_search();
        finish_search(got);
        total++; if (!got) begin bad++; $display("FAIL midrst_rerun_timeout got=0 want=1"); end
        total++; if (obs_q.size() != 64) begin bad++; $display("FAIL midrst_rerun_issues got=%0d want=64", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL midrst_issue_idx got=%0d want=%0d", o, e); end
        end
        total++; if (BestSad !== 12'd37 || BestCount !== 6'd63 || Err !== 1'b0) begin bad++; $display("FAIL midrst_rerun_best got=%0d@%0d/%0b want=37@63/0", BestSad, BestCount, Err); end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_num_pos1();
        bit got;
        Start1 = 1'b1;
        @(posedge Clk); #1;
        total++; if (C_EN1 !== 1'b1 || Count1 !== 6'd0 || Busy1 !== 1'b1) begin bad++; $display("FAIL np1_issue got=%0b/%0d/%0b want=1/0/1", C_EN1, Count1, Busy1); end
        SadValid1 = 1'b1; Sad1 = 12'd7; SadCount1 = 6'd0;
        @(posedge Clk); #1;
        SadValid1 = 1'b0;
        total++; if (C_EN1 !== 1'b0) begin bad++; $display("FAIL np1_single_issue got=%0b want=0", C_EN1); end
        @(posedge Clk); #1;
        total++; if (Done1 !== 1'b1 || BestSad1 !== 12'd7 || BestCount1 !== 6'd0) begin bad++; $display("FAIL np1_done got=%0b/%0d@%0d want=1/7@0", Done1, BestSad1, BestCount1); end
        @(posedge Clk); #1;
        total++; if (Done1 !== 1'b0 || Busy1 !== 1'b0 || C_EN1 !== 1'b0) begin bad++; $display("FAIL np1_start_ignored_in_done got=%0b/%0b/%0b want=0/0/0", Done1, Busy1, C_EN1); end
        @(posedge Clk); #1;
        total++; if (C_EN1 !== 1'b1 || Busy1 !== 1'b1) begin bad++; $display("FAIL np1_restart got=%0b/%0b want=1/1", C_EN1, Busy1); end
        Start1 = 1'b0;
        SadValid1 = 1'b1; Sad1 = 12'd9; SadCount1 = 6'd0;
        @(posedge Clk); #1;
        SadValid1 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (Done1) got = 1'b1;
            else begin @(posedge Clk); #1; end
        end
        total++; if (!got || BestSad1 !== 12'd9 || Err1 !== 1'b0) begin bad++; $display("FAIL np1_second got=%0b/%0d/%0b want=1/9/0", got, BestSad1, Err1); end
    endtask

    initial begin
        Rst = 1'b1; Start = 1'b0; Stall = 1'b0; SadValid = 1'b0; Sad = '0; SadCount = '0;
        Start1 = 1'b0; Stall1 = 1'b0; SadValid1 = 1'b0; Sad1 = '0; SadCount1 = '0;
        for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; ps[i] = '0; pt[i] = '0; end
        mode = 0; corrupt = -1; stall_lo = 1000; stall_hi = -1; cyc = -1; done_cnt = 0;
        #12;
        test_reset();
        test_basic();
        test_stall();
        test_tie();
        test_tag_err();
        test_mid_reset();
        test_num_pos1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sad_search_ctrl.md
Name: sad_search_ctrl

Overview:
- Sequences one block-match search through the SAD execute datapath.
- Issues candidate indices Count=0..NUM_POS-1 with C_EN into the EX pipeline register.
- Collects tagged SAD results returned from the end of the pipeline and tracks the minimum SAD and its index.
- Reports completion with a start/done handshake; sits between the top-level sequencer and the EX stage.

Parameters:
- NUM_POS, 64, candidate positions per search; legal range 1..64.
- SAD_W, 12, SAD result width; 16 pairs x 255 = 4080 fits in 12 bits.

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous, active-high reset
- Start  in  1  begin a search; sampled only in IDLE
- Stall  in  1  hold issue this cycle
- Count  out  6  candidate index driven to the EX register
- C_EN  out  1  issue-valid to the EX register
- SadValid  in  1  result valid from the pipeline tail
- Sad  in  SAD_W  result value
- SadCount  in  6  index tag carried with the result
- Busy  out  1  high in ISSUE, DRAIN and DONE
- Done  out  1  one-cycle completion pulse
- BestSad  out  SAD_W  minimum SAD of the last or current search
- BestCount  out  6  index of BestSad
- Err  out  1  sticky result-sequence error

Behaviour:
- Async Rst, effective immediately, including mid-search:
  - state=IDLE, Count=0, C_EN=0, Busy=0, Done=0, Err=0.
  - BestSad all ones, BestCount=0, internal result counter RxCnt=0.
  - Any in-flight results arriving after reset are ignored because SadValid is ignored in IDLE.
- States are IDLE, ISSUE, DRAIN and DONE. All outputs are registered.
- IDLE:
  - C_EN=0, Count=0.
  - Start=1 -> next state ISSUE.
  - On that edge: BestSad<=all ones, BestCount<=0, RxCnt<=0, Err<=0.
  - Start is ignored in every other state.
- ISSUE:
  - C_EN=1 on every cycle with Stall=0, with Count = current index.
  - Stall=1: C_EN=0 that cycle and Count holds.
  - After an issued Count==NUM_POS-1 -> DRAIN, with C_EN=0 and Count=0 on entry.
  - Exactly NUM_POS issues per search.
  - The first issue appears on the cycle after Start is accepted.
- Result handling (ISSUE and DRAIN), on SadValid=1:
  - Expected tag is RxCnt[5:0]. If SadCount != expected, Err<=1 (sticky until next Start); the result is still compared.
  - RxCnt increments on each valid result.
  - Update rule: if Sad < BestSad (strict), BestSad<=Sad and BestCount<=SadCount. Ties keep the earlier index.
  - Results may arrive during ISSUE when pipeline latency is shorter than the issue run.
- DRAIN:
  - When a valid result makes RxCnt reach NUM_POS -> DONE.
  - That final result is compared before leaving DRAIN.
  - Latency-agnostic: no fixed pipeline depth is assumed.
- DONE: Done=1 for exactly one cycle, then -> IDLE.
  - BestSad, BestCount and Err hold until the next accepted Start.
  - A Start asserted during DONE is ignored; it must be re-asserted in IDLE.
- Simultaneous events:
  - Stall and SadValid are independent; a result is consumed even while issue is stalled.
  - NUM_POS=1: ISSUE lasts one unstalled cycle, then DRAIN.
- Width and wrap:
  - RxCnt is 7 bits so NUM_POS=64 can be counted.
  - Count never wraps within a search.
  - Extra results after DONE (SadValid in IDLE) are ignored and do not set Err.

Test Plan:
- Reset, then Start with NUM_POS=64, no stalls, 3-cycle loopback returning Sad=100-idx -> C_EN high for 64 consecutive cycles with Count 0..63; Done pulses once; BestSad=37, BestCount=63, Err=0.
- Stall=1 for cycles 5-7 of ISSUE -> C_EN=0 and Count held at 5 for 3 cycles; still exactly 64 issues; result unchanged from the first scenario.
- Loopback Sad=50 for all indices -> tie rule: BestSad=50, BestCount=0.
- Loopback corrupting the tag of result 10 to 11 -> Err=1 after Done; Err clears on the next Start.
- Rst asserted mid-ISSUE at Count=20 -> immediately C_EN=0, Count=0, Busy=0, BestSad=all ones; late results ignored; a new Start runs cleanly.
- NUM_POS=1 with Sad=7, and Start held high through DONE -> one issue, Done pulse, BestSad=7, BestCount=0; the second search begins only after Start is seen in IDLE.
